tnn_feature_encoder: RTL
========================

# tnn_feature_encoder

Front-end feeder for the evolved 2-bit ternary-NN classifiers, such as the 7-feature breast-cancer `cgp` cores. It accepts a stream of raw 8-bit feature samples and quantises each one to 2 bits against three programmable per-feature thresholds. It assembles seven quantised features into one 14-bit vector and holds that vector stable, under a valid/ready handshake, until the classifier stage consumes it. It is the producer end of the classifier's `input_a`..`input_g` interface.

## Interface
- `N_FEAT`, default 7: features per vector; fixed at 7 for the current classifier family.
- `RAW_W`, default 8: raw sample width.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `s_valid`  in  1  raw sample valid.
- `s_ready`  out  1  encoder can accept a sample.
- `s_data`  in  RAW_W  raw feature sample, in feature order 0..6.
- `s_last`  in  1  marks the sample for feature 6.
- `cfg_we`  in  1  threshold write strobe.
- `cfg_feat`  in  3  feature index, 0..6.
- `cfg_lvl`  in  2  threshold level, 0..2.
- `cfg_data`  in  RAW_W  threshold value.
- `m_valid`  out  1  vector valid.
- `m_ready`  in  1  classifier stage accepts the vector.
- `m_vec`  out  2*N_FEAT  quantised vector; feature k occupies bits [2k+1:2k] (feature 0 = `input_a`, feature 6 = `input_g`).
- `err_len`  out  1  one-cycle pulse on a framing error.
- `vec_count`  out  16  number of vectors handed off; wraps modulo 2^16.

## Operation
- Threshold table: 7×3 registers of width RAW_W.
  - Reset values: level0=64, level1=128, level2=192 for every feature.
  - A write with `cfg_feat`>6 or `cfg_lvl`=3 is ignored.
- Quantisation: q = number of levels l with `s_data` >= thr[feat][l].
  - Range is 0..3; the thresholds need not be ordered.
- FSM states:
  - COLLECT: `s_ready`=1, `m_valid`=0.
  - FULL: `s_ready`=0, `m_valid`=1.
- In COLLECT, each accepted beat (`s_valid`&`s_ready`) writes q into slot `idx` and increments `idx` (0..6).
- Beat with idx=6:
  - Vector completes and the FSM goes to FULL; `idx` resets to 0.
  - If `s_last`=0, the vector is still emitted and `err_len` pulses.
- Beat with `s_last`=1 and idx<6:
  - Partial vector is discarded, `idx`←0, FSM stays in COLLECT, `err_len` pulses.
  - Slots written so far are not cleared; they are overwritten by the next frame.
- In FULL: `m_vec` is stable; when `m_valid`&`m_ready`, FSM→COLLECT and `vec_count` increments.
- Simultaneous threshold write and sample beat:
  - The sample is quantised with the old threshold.
  - The new threshold applies from the next cycle.
- Reset values: `s_ready`=1 once reset is released, `m_valid`=0, `m_vec`=0, `err_len`=0, `vec_count`=0, `idx`=0, FSM=COLLECT.
- Reset mid-frame or during FULL discards the vector and restores the threshold reset values.

## Timing
- Quantisation is combinational at the beat; the result is registered into the slot on the same edge.
- Latency: 7th beat accepted at edge n → `m_valid`=1 after edge n.
- Handoff at edge m → `s_ready`=1 after edge m, giving one bubble cycle per vector.
- Best-case throughput: one vector per 8 cycles.
- `s_ready` and `m_valid` are registered state decodes with no combinational path from `m_ready`.
- `err_len` is registered and asserted for exactly one cycle, in the cycle after the offending beat.

## Structure
- Package `tnn_enc_pkg`:
  - constants `N_FEAT`, `Q_W`=2, `N_LVL`=3;
  - reset thresholds `THR_RST[3]` = {64,128,192};
  - state enum {COLLECT, FULL}.
- Sub-module `tnn_quant2`: combinational RAW_W sample plus 3 thresholds → 2-bit q. One instance muxed by `idx`.
- Top level holds the threshold table, slot registers, FSM and counter.

## Test plan
- After reset, stream 0,63,64,127,128,191,255 with `s_last` on the 7th beat, `m_ready`=1 → `m_vec`=0x3A50, `vec_count`=1, `err_len` never asserted.
- Hold `m_ready`=0 for 10 cycles after the vector completes → `m_vec` stable, `m_valid`=1, `s_ready`=0 throughout; accept → next beat is taken one cycle later.
- Write thr[3] = {10,20,30}, then send 25 as feature 3 (others 0) → `m_vec`[7:6]=2, all other slots 0.
- `s_last` on the 4th beat → `err_len` pulse, no `m_valid`; the next full frame of 255s → `m_vec`=0x3FFF.
- Seven beats with `s_last`=0 → vector emitted and `err_len` pulses once.
- Assert `rst` during FULL → `m_valid`=0 and `vec_count`=0 immediately; thresholds return to 64/128/192.

Source files
------------

// File: rtl/tnn_enc_pkg.sv
// Shared constants, reset thresholds and FSM encoding for the ternary-NN feature encoder.
package tnn_enc_pkg;

    localparam int N_FEAT = 7;
    localparam int Q_W    = 2;
    localparam int N_LVL  = 3;

    localparam int THR_RST [N_LVL] = '{64, 128, 192};

    typedef enum logic {
        COLLECT = 1'b0,
        FULL    = 1'b1
    } enc_state_e;

endpackage

// File: rtl/tnn_quant2.sv
// Combinational 2-bit quantiser: counts how many of three thresholds the sample meets or exceeds.
module tnn_quant2
    import tnn_enc_pkg::*;
#(
    parameter int RAW_W = 8
) (
    input  logic [RAW_W-1:0] sample_i,
    input  logic [RAW_W-1:0] thr0_i,
    input  logic [RAW_W-1:0] thr1_i,
    input  logic [RAW_W-1:0] thr2_i,
    output logic [Q_W-1:0]   q_o
);

    logic ge0, ge1, ge2;

    // Thresholds may be unordered, so each level is counted independently.
    assign ge0 = (sample_i >= thr0_i);
    assign ge1 = (sample_i >= thr1_i);
    assign ge2 = (sample_i >= thr2_i);

    assign q_o = Q_W'({1'b0, ge0}) + Q_W'({1'b0, ge1}) + Q_W'({1'b0, ge2});

endmodule

// File: rtl/tnn_feature_encoder.sv
// Quantises a stream of raw feature samples into a 14-bit ternary-NN input vector
// and holds it under a valid/ready handshake until the classifier consumes it.
module tnn_feature_encoder #(
    parameter int N_FEAT = 7,
    parameter int RAW_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [RAW_W-1:0]      s_data,
    input  logic                  s_last,
    input  logic                  cfg_we,
    input  logic [2:0]            cfg_feat,
    input  logic [1:0]            cfg_lvl,
    input  logic [RAW_W-1:0]      cfg_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [2*N_FEAT-1:0]   m_vec,
    output logic                  err_len,
    output logic [15:0]           vec_count
);

    import tnn_enc_pkg::*;

    localparam int IDX_W = $clog2(N_FEAT);

    logic [RAW_W-1:0] thr_q [N_FEAT][N_LVL];
    logic [Q_W-1:0]   slot_q [N_FEAT];
    logic [IDX_W-1:0] idx_q, idx_d;
    enc_state_e       state_q, state_d;
    logic             err_q, err_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             beat;
    logic [Q_W-1:0]   q;

    assign s_ready   = (state_q == COLLECT);
    assign m_valid   = (state_q == FULL);
    assign err_len   = err_q;
    assign vec_count = cnt_q;
    assign beat      = s_valid && (state_q == COLLECT);

    // A single quantiser serves every feature; the current slot selects its thresholds.
    tnn_quant2 #(.RAW_W(RAW_W)) u_quant (
        .sample_i (s_data),
        .thr0_i   (thr_q[idx_q][0]),
        .thr1_i   (thr_q[idx_q][1]),
        .thr2_i   (thr_q[idx_q][2]),
        .q_o      (q)
    );

    always_comb begin
        m_vec = '0;
        for (int k = 0; k < N_FEAT; k++) begin
            m_vec[2*k +: 2] = slot_q[k];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        case (state_q)
            COLLECT: begin
                if (beat) begin
                    if (idx_q == IDX_W'(N_FEAT - 1)) begin
                        state_d = FULL;
                        idx_d   = '0;
                        err_d   = !s_last;
                    end else if (s_last) begin
                        idx_d = '0;
                        err_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            FULL: begin
                if (m_ready) begin
                    state_d = COLLECT;
                    cnt_d   = cnt_q + 16'd1;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
            idx_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Slots are not cleared on a framing error; the next frame overwrites them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_FEAT; k++) begin
                slot_q[k] <= '0;
            end
        end else if (beat) begin
            slot_q[idx_q] <= q;
        end
    end

    // Out-of-range feature or level writes match no entry and are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int f = 0; f < N_FEAT; f++) begin
                for (int l = 0; l < N_LVL; l++) begin
                    thr_q[f][l] <= RAW_W'(THR_RST[l]);
                end
            end
        end else if (cfg_we) begin
            for (int f = 0; f < N_FEAT; f++) begin
                for (int l = 0; l < N_LVL; l++) begin
                    if (cfg_feat == 3'(f) && cfg_lvl == 2'(l)) begin
                        thr_q[f][l] <= cfg_data;
                    end
                end
            end
        end
    end

endmodule
